wb_unit: RTL

Writeback unit for the 5-stage pipeline. It consumes the MEM/WB latch outputs and drives the register-file write port. It also accepts completions from the multi-cycle mult/div unit, holding them in a small in-order queue until the write port is free. Pipeline writes always win the port. Queued results that a newer pipeline write has superseded (write-after-write) are dropped.

---
 rtl/wb_unit.sv | 212 +++++++++++++++++++++
 1 files changed

// File: rtl/wb_unit.sv
// Writeback unit: decodes the MEM/WB latch into a register-file write and merges
// mult/div completions through a small in-order queue that the pipeline always pre-empts.
module wb_unit #(
  parameter int unsigned DEPTH = 2,
  localparam int unsigned CW   = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic [31:0]   o_out,
  input  logic [31:0]   d_out,
  input  logic [31:0]   ins_out,
  input  logic          ovf_out,
  input  logic          md_valid,
  output logic          md_ready,
  input  logic [31:0]   md_result,
  input  logic [4:0]    md_rd,
  input  logic          md_exception,
  input  logic          md_is_div,
  output logic          ctrl_writeEnable,
  output logic [4:0]    ctrl_writeReg,
  output logic [31:0]   data_writeReg,
  output logic [CW-1:0] md_count
);

  localparam logic [4:0] OpAlu  = 5'b00000;
  localparam logic [4:0] OpAddi = 5'b00101;
  localparam logic [4:0] OpLw   = 5'b01000;
  localparam logic [4:0] OpJal  = 5'b00011;
  localparam logic [4:0] OpSetx = 5'b10101;

  localparam logic [4:0] AluAdd = 5'b00000;
  localparam logic [4:0] AluSub = 5'b00001;
  localparam logic [4:0] AluMul = 5'b00110;
  localparam logic [4:0] AluDiv = 5'b00111;

  localparam logic [4:0] RegExc = 5'd30;
  localparam logic [4:0] RegRa  = 5'd31;

  logic [4:0] opcode, rd_field, alu_op;
  assign opcode   = ins_out[31:27];
  assign rd_field = ins_out[26:22];
  assign alu_op   = ins_out[6:2];

  // Pipeline write decode.
  logic        pipe_we;
  logic        pipe_exc;
  logic [4:0]  pipe_rd;
  logic [31:0] pipe_data;

  always_comb begin
    pipe_we   = 1'b0;
    pipe_exc  = 1'b0;
    pipe_rd   = '0;
    pipe_data = '0;
    case (opcode)
      OpAlu: begin
        if (alu_op != AluMul && alu_op != AluDiv) begin
          pipe_we = 1'b1;
          if (ovf_out && alu_op == AluAdd) begin
            pipe_exc  = 1'b1;
            pipe_rd   = RegExc;
            pipe_data = 32'd1;
          end else if (ovf_out && alu_op == AluSub) begin
            pipe_exc  = 1'b1;
            pipe_rd   = RegExc;
            pipe_data = 32'd3;
          end else begin
            pipe_rd   = rd_field;
            pipe_data = o_out;
          end
        end
      end
      OpAddi: begin
        pipe_we = 1'b1;
        if (ovf_out) begin
          pipe_exc  = 1'b1;
          pipe_rd   = RegExc;
          pipe_data = 32'd2;
        end else begin
          pipe_rd   = rd_field;
          pipe_data = o_out;
        end
      end
      OpLw: begin
        pipe_we   = 1'b1;
        pipe_rd   = rd_field;
        pipe_data = d_out;
      end
      OpJal: begin
        pipe_we   = 1'b1;
        pipe_rd   = RegRa;
        pipe_data = o_out;
      end
      OpSetx: begin
        pipe_we   = 1'b1;
        pipe_rd   = RegExc;
        pipe_data = {5'b0, ins_out[26:0]};
      end
      default: ;
    endcase
    if (!pipe_exc && pipe_rd == 5'd0) begin
      pipe_we = 1'b0;
    end
  end

  // Queue state: shift-register storage, entry 0 is the head.
  logic [4:0]    tgt_q  [DEPTH];
  logic [31:0]   data_q [DEPTH];
  logic [4:0]    tgt_d  [DEPTH];
  logic [31:0]   data_d [DEPTH];
  logic [CW-1:0] count_q, count_d;

  // Incoming md entry, already resolved to its final target and data.
  logic [4:0]  md_tgt;
  logic [31:0] md_data;
  logic        md_null;

  always_comb begin
    md_null = 1'b0;
    if (md_exception) begin
      md_tgt  = RegExc;
      md_data = md_is_div ? 32'd5 : 32'd4;
    end else begin
      md_tgt  = md_rd;
      md_data = md_result;
      md_null = (md_rd == 5'd0);
    end
  end

  logic q_empty, md_fire, md_kill, bypass, drain, enq;

  assign q_empty  = (count_q == '0);
  assign md_ready = (count_q < CW'(DEPTH)) & reset_n;
  assign md_fire  = md_valid & md_ready;
  assign md_kill  = pipe_we & (md_tgt == pipe_rd);
  assign bypass   = md_fire & q_empty & ~pipe_we;
  assign drain    = ~pipe_we & ~q_empty;
  assign enq      = md_fire & ~bypass & ~md_kill & ~md_null;
  assign md_count = count_q;

  // Write-port arbitration: pipeline, then queue head, then md bypass.
  always_comb begin
    ctrl_writeEnable = 1'b0;
    ctrl_writeReg    = '0;
    data_writeReg    = '0;
    if (reset_n) begin
      if (pipe_we) begin
        ctrl_writeEnable = 1'b1;
        ctrl_writeReg    = pipe_rd;
        data_writeReg    = pipe_data;
      end else if (!q_empty) begin
        ctrl_writeEnable = 1'b1;
        ctrl_writeReg    = tgt_q[0];
        data_writeReg    = data_q[0];
      end else if (bypass && !md_null) begin
        ctrl_writeEnable = 1'b1;
        ctrl_writeReg    = md_tgt;
        data_writeReg    = md_data;
      end
    end
  end

  // Next queue: drop the drained head and WAW-killed entries, compact, then append.
  always_comb begin
    int n;
    logic keep;
    for (int j = 0; j < DEPTH; j++) begin
      tgt_d[j]  = tgt_q[j];
      data_d[j] = data_q[j];
    end
    n = 0;
    for (int i = 0; i < DEPTH; i++) begin
      keep = (CW'(i) < count_q) && !(drain && i == 0) && !(pipe_we && tgt_q[i] == pipe_rd);
      if (keep) begin
        for (int j = 0; j < DEPTH; j++) begin
          if (j == n) begin
            tgt_d[j]  = tgt_q[i];
            data_d[j] = data_q[i];
          end
        end
        n = n + 1;
      end
    end
    if (enq) begin
      for (int j = 0; j < DEPTH; j++) begin
        if (j == n) begin
          tgt_d[j]  = md_tgt;
          data_d[j] = md_data;
        end
      end
      n = n + 1;
    end
    count_d = CW'(n);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        tgt_q[i]  <= '0;
        data_q[i] <= '0;
      end
    end else begin
      count_q <= count_d;
      for (int i = 0; i < DEPTH; i++) begin
        tgt_q[i]  <= tgt_d[i];
        data_q[i] <= data_d[i];
      end
    end
  end

endmodule
